// File: rtl/spi_tx_sequencer.sv
// Purpose:      byte FIFO feeding an SPI master; launches one frame per byte and times it with a counter.
// Latency:      start rises 1 cycle after the pop; frame period 1+FRAME_CYCLES+GAP_CYCLES cycles.
// Backpressure: in_ready low while the FIFO holds DEPTH bytes; the SPI side has no backpressure.
//
// Optional build macro: SPI_TX_LOOPBACK_CHECK_EN compares rcvd_p_dat with p_dat at frame end.
// Ports: clk/rst_n; in_data/in_valid/in_ready byte input; cfg_mode {cpol,cpha};
//        start/p_dat/cpol/cpha to the SPI master; busy, fifo_count status;
//        rcvd_p_dat loopback byte; chk_err/err_cnt loopback mismatch status.

// Purpose:      generic synchronous FIFO, power-of-two depth.
// Latency:      written data visible at rd_dat the cycle after the write.
// Backpressure: wr_rdy low when full; rd_pop ignored when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [W-1:0]           wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_pop,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_fire, rd_fire;

    assign wr_rdy  = (count != CW'(DEPTH));
    assign rd_vld  = (count != '0);
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_pop && rd_vld;
    assign rd_dat  = mem[rd_ptr];

    // Storage is not reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_tx_sequencer #(
    parameter int DEPTH        = 8,
    parameter int START_HOLD   = 2,
    parameter int FRAME_CYCLES = 40,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             cfg_mode,
    output logic                   start,
    output logic [7:0]             p_dat,
    output logic                   cpol,
    output logic                   cpha,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic [7:0]             rcvd_p_dat,
    output logic                   chk_err,
    output logic [7:0]             err_cnt
);
    // The counter must also reach START_HOLD-1 when the hold outlasts the frame.
    localparam int CMAX_FG = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CMAX    = (CMAX_FG > START_HOLD) ? CMAX_FG : START_HOLD;
    localparam int TW      = $clog2(CMAX + 1);

    localparam logic [TW-1:0] HOLD_LAST  = TW'(START_HOLD - 1);
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam bit            SKIP_WAIT  = (START_HOLD >= FRAME_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          pop;
    logic          fifo_vld;
    logic [7:0]    fifo_dat;

    sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (in_data),
        .rd_vld (fifo_vld),
        .rd_pop (pop),
        .rd_dat (fifo_dat),
        .count  (fifo_count)
    );

    // One counter times START and WAIT back to back (frame measured from start rise),
    // then restarts from zero for the GAP.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + 1'b1;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_nxt = '0;
                if (fifo_vld) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tmr == HOLD_LAST) begin
                    if (SKIP_WAIT) begin
                        state_nxt = S_GAP;
                        tmr_nxt   = '0;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (tmr == FRAME_LAST) begin
                    state_nxt = S_GAP;
                    tmr_nxt   = '0;
                end
            end
            S_GAP: begin
                if (tmr == GAP_LAST) begin
                    state_nxt = S_IDLE;
                    tmr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tmr   <= '0;
            p_dat <= '0;
            cpol  <= 1'b0;
            cpha  <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            // Frame outputs move only at the pop, so they stay put for the whole frame.
            if (pop) begin
                p_dat <= fifo_dat;
                cpol  <= cfg_mode[1];
                cpha  <= cfg_mode[0];
            end
        end
    end

    // Decoded from state so an asynchronous reset drops start immediately.
    assign start = (state == S_START);
    assign busy  = (state != S_IDLE) || (fifo_count != '0);

`ifdef SPI_TX_LOOPBACK_CHECK_EN
    logic frame_done;
    assign frame_done = (state == S_WAIT) && (tmr == FRAME_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
            err_cnt <= '0;
        end else if (frame_done && (rcvd_p_dat != p_dat)) begin
            chk_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_rcvd;
    assign unused_rcvd = ^rcvd_p_dat;
    assign chk_err     = 1'b0;
    assign err_cnt     = '0;
`endif
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Purpose:      directed bench for spi_tx_sequencer with default parameters.
// Latency:      expects start 1 cycle after pop and a 45-cycle frame period.
// Backpressure: holds in_valid until in_ready, bounded by a cycle budget.
module tb_spi_tx_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] cfg_mode = '0;
    logic       start;
    logic [7:0] p_dat;
    logic       cpol, cpha, busy;
    logic [3:0] fifo_count;
    logic [7:0] rcvd_p_dat;
    logic       chk_err;
    logic [7:0] err_cnt;
    logic       lb_force = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    logic [1:0] rise_mode[$];
    logic       start_d = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Loopback peripheral model: echoes the sent byte unless forced to zero.
    assign rcvd_p_dat = lb_force ? 8'h00 : p_dat;

    spi_tx_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .p_dat      (p_dat),
        .cpol       (cpol),
        .cpha       (cpha),
        .busy       (busy),
        .fifo_count (fifo_count),
        .rcvd_p_dat (rcvd_p_dat),
        .chk_err    (chk_err),
        .err_cnt    (err_cnt)
    );

    // Record every start rise with the frame outputs seen at that moment.
    always @(negedge clk) begin
        if (start && !start_d) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(p_dat);
            rise_mode.push_back({cpol, cpha});
        end
        start_d = start;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        lb_force = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rise_cyc.delete();
        rise_dat.delete();
        rise_mode.delete();
    endtask

    // Present d until accepted; returns the number of cycles spent waiting.
    task automatic push_hold(input logic [7:0] d, output int waited);
        bit done;
        bit rdy;
        done     = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) done = 1'b1;
            else     waited++;
        end
        in_valid = 1'b0;
        chk("push_accept", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        int starts, busyn;
        bit stable, ok;
        logic [7:0] exp_order [10];

        // ---------------- T2: single frame ----------------
        do_reset();
        cfg_mode = 2'b10;
        push_hold(8'hA5, w);
        chk("t2_cnt_after_write", fifo_count, 1);
        chk("t2_start_before_pop", start, 0);
        tick();
        chk("t2_start_rise", start, 1);
        chk("t2_p_dat", p_dat, 8'hA5);
        chk("t2_cpol", cpol, 1);
        chk("t2_cpha", cpha, 0);
        chk("t2_cnt_after_pop", fifo_count, 0);
        starts = 1; busyn = 1; stable = 1'b1;
        for (int i = 1; i < 50; i++) begin
            if (i == 5) cfg_mode = 2'b01;
            tick();
            starts += int'(start);
            busyn  += int'(busy);
            if (p_dat != 8'hA5 || cpol != 1'b1 || cpha != 1'b0) stable = 1'b0;
        end
        chk("t2_start_len", starts, 2);
        chk("t2_busy_len", busyn, 44);
        chk("t2_outputs_stable", stable, 1);
        chk("t2_rises", rise_cyc.size(), 1);

        // ---------------- T5 + T4: simultaneous write/pop, back-to-back ----------------
        do_reset();
        cfg_mode = 2'b00;
        push_hold(8'h11, w);
        push_hold(8'h22, w);
        chk("t5_cnt_write_pop", fifo_count, 1);
        chk("t5_popped", start, 1);
        push_hold(8'h33, w);
        chk("t4_cnt_two", fifo_count, 2);
        for (int i = 0; i < 150; i++) begin
            if (i == 10) cfg_mode = 2'b11;
            tick();
        end
        chk("t4_rises", rise_cyc.size(), 3);
        if (rise_cyc.size() >= 3) begin
            chk("t4_gap_1_2", rise_cyc[1] - rise_cyc[0], 45);
            chk("t4_gap_2_3", rise_cyc[2] - rise_cyc[1], 45);
            chk("t4_dat0", rise_dat[0], 8'h11);
            chk("t4_dat1", rise_dat[1], 8'h22);
            chk("t4_dat2", rise_dat[2], 8'h33);
            chk("t4_mode0", rise_mode[0], 2'b00);
            chk("t4_mode1", rise_mode[1], 2'b11);
        end
        chk("t4_drained_cnt", fifo_count, 0);
        chk("t4_drained_busy", busy, 0);

        // ---------------- T3: fill to DEPTH while a frame is running ----------------
        do_reset();
        cfg_mode = 2'b01;
        push_hold(8'h5A, w);
        run(3);
        wsum = 0;
        for (int k = 0; k < 8; k++) begin
            push_hold(8'h40 + 8'(k), w);
            wsum += w;
        end
        chk("t3_no_stall", wsum, 0);
        chk("t3_full_cnt", fifo_count, 8);
        chk("t3_full_rdy", in_ready, 0);
        push_hold(8'h48, w);
        chk("t3_ninth_waited", w > 0, 1);
        chk("t3_cnt_after_ninth", fifo_count, 8);
        run(430);
        exp_order[0] = 8'h5A;
        for (int k = 0; k < 9; k++) exp_order[k+1] = 8'h40 + 8'(k);
        ok = (rise_dat.size() == 10);
        for (int k = 0; k < 10 && k < rise_dat.size(); k++)
            if (rise_dat[k] != exp_order[k]) ok = 1'b0;
        chk("t3_order", ok, 1);
        chk("t3_drained", fifo_count, 0);

        // ---------------- T1: asynchronous reset mid-WAIT ----------------
        do_reset();
        push_hold(8'h77, w);
        push_hold(8'h88, w);
        run(10);
        chk("t1_pre_busy", busy, 1);
        chk("t1_pre_cnt", fifo_count, 1);
        chk("t1_pre_p_dat", p_dat, 8'h77);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t1_start", start, 0);
        chk("t1_cnt", fifo_count, 0);
        chk("t1_rdy", in_ready, 1);
        chk("t1_busy", busy, 0);
        chk("t1_p_dat", p_dat, 0);
        chk("t1_cpol_cpha", {cpol, cpha}, 2'b00);
        chk("t1_chk_err", chk_err, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // ---------------- T6: loopback compare ----------------
        do_reset();
`ifdef SPI_TX_LOOPBACK_CHECK_EN
        push_hold(8'h3C, w);
        run(50);
        chk("t6_match_no_err", chk_err, 0);
        lb_force = 1'b1;
        push_hold(8'h3C, w);
        run(50);
        chk("t6_chk_err", chk_err, 1);
        chk("t6_err_cnt_1", err_cnt, 1);
        for (int f = 0; f < 300; f++) push_hold(8'h3C, w);
        run(500);
        chk("t6_err_sat", err_cnt, 255);
        chk("t6_err_sticky", chk_err, 1);
`else
        lb_force = 1'b1;
        push_hold(8'h3C, w);
        run(50);
        chk("t6_off_chk_err", chk_err, 0);
        chk("t6_off_err_cnt", err_cnt, 0);
        chk("t6_off_frame_sent", rise_dat.size(), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
